// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register master
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_TX_BYTE,
        ST_RX_ACK,
        ST_RESTART,
        ST_RX_BYTE,
        ST_TX_NACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic       RW_WRITE     = 1'b0;
    localparam logic       RW_READ      = 1'b1;
    localparam logic [6:0] MPU9250_ADDR = 7'h68;

    localparam int BIT_W  = 4;
    localparam int QIDX_W = 2;

    function automatic int qtr_cycles(input int clk_hz, input int i2c_hz);
        return clk_hz / (i2c_hz * 4);
    endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// rtl/i2c_qtr_tick.sv - quarter-bit divider with clear/enable and one-cycle tick
module i2c_qtr_tick #(
    parameter int QTR = 31
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(QTR);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(QTR - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_reg_master.sv
// rtl/i2c_reg_master.sv - single-byte register write/read engine on an open-drain I2C bus
module i2c_reg_master
    import i2c_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int I2C_HZ = 400_000,
    parameter int QTR    = qtr_cycles(CLK_HZ, I2C_HZ)
) (
    input  logic       iclk50,
    input  logic       irst_n,
    input  logic       istart,
    input  logic       irw,
    input  logic [6:0] idev_addr,
    input  logic [7:0] ireg_addr,
    input  logic [7:0] iwdata,
    input  logic       isda_in,
    output logic [7:0] ordata,
    output logic       obusy,
    output logic       odone,
    output logic       oack_err,
    output logic       oscl_oe,
    output logic       osda_oe
);

    state_t              state, nxt_state;
    logic [QIDX_W-1:0]   q, nxt_q;
    logic [BIT_W-1:0]    bit_idx, nxt_bit;
    logic [1:0]          byte_sel, nxt_sel;
    logic [7:0]          tx_shift, nxt_tx;
    logic [7:0]          rx_shift;
    logic                rw_r;
    logic [6:0]          dev_r;
    logic [7:0]          reg_r, wdata_r;
    logic                ack_bit;
    logic                accept, tick, nack_set;
    logic                scl_nxt, sda_nxt;

    assign accept = istart && !obusy;

    i2c_qtr_tick #(.QTR(QTR)) u_tick (
        .clk    (iclk50),
        .resetn (irst_n),
        .clr    (accept),
        .en     (obusy),
        .tick   (tick)
    );

    // byte_sel: 0 = address+W, 1 = register index, 2 = write data or address+R
    always_comb begin
        nxt_state = state;
        nxt_q     = q;
        nxt_bit   = bit_idx;
        nxt_sel   = byte_sel;
        nxt_tx    = tx_shift;
        nack_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt_state = ST_START;
                    nxt_q     = '0;
                end
            end
            ST_DONE: nxt_state = ST_IDLE;
            default: begin
                if (tick) begin
                    nxt_q = q + 2'd1;
                    if (q == 2'd3) begin
                        nxt_bit = '0;
                        case (state)
                            ST_START: begin
                                nxt_state = ST_TX_BYTE;
                                nxt_sel   = 2'd0;
                                nxt_tx    = {dev_r, RW_WRITE};
                            end
                            ST_TX_BYTE: begin
                                if (bit_idx == 4'd7) begin
                                    nxt_state = ST_RX_ACK;
                                end else begin
                                    nxt_bit = bit_idx + 4'd1;
                                    nxt_tx  = {tx_shift[6:0], 1'b0};
                                end
                            end
                            ST_RX_ACK: begin
                                if (ack_bit) begin
                                    nack_set  = 1'b1;
                                    nxt_state = ST_STOP;
                                end else if (byte_sel == 2'd0) begin
                                    nxt_state = ST_TX_BYTE;
                                    nxt_sel   = 2'd1;
                                    nxt_tx    = reg_r;
                                end else if (byte_sel == 2'd1 && rw_r == RW_WRITE) begin
                                    nxt_state = ST_TX_BYTE;
                                    nxt_sel   = 2'd2;
                                    nxt_tx    = wdata_r;
                                end else if (byte_sel == 2'd1) begin
                                    nxt_state = ST_RESTART;
                                end else if (rw_r == RW_READ) begin
                                    nxt_state = ST_RX_BYTE;
                                end else begin
                                    nxt_state = ST_STOP;
                                end
                            end
                            ST_RESTART: begin
                                nxt_state = ST_TX_BYTE;
                                nxt_sel   = 2'd2;
                                nxt_tx    = {dev_r, RW_READ};
                            end
                            ST_RX_BYTE: begin
                                if (bit_idx == 4'd7) nxt_state = ST_TX_NACK;
                                else                 nxt_bit   = bit_idx + 4'd1;
                            end
                            ST_TX_NACK: nxt_state = ST_STOP;
                            ST_STOP:    nxt_state = ST_DONE;
                            default:    nxt_state = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pad enables for the quarter being entered, so they register exactly at quarter boundaries.
    always_comb begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
        case (nxt_state)
            ST_START: begin
                scl_nxt = (nxt_q == 2'd3);
                sda_nxt = nxt_q[1];
            end
            ST_RESTART: begin
                scl_nxt = (nxt_q == 2'd0) || (nxt_q == 2'd3);
                sda_nxt = nxt_q[1];
            end
            ST_TX_BYTE: begin
                scl_nxt = ~nxt_q[1];
                sda_nxt = ~nxt_tx[7];
            end
            ST_RX_ACK, ST_RX_BYTE, ST_TX_NACK: scl_nxt = ~nxt_q[1];
            ST_STOP: begin
                scl_nxt = ~nxt_q[1];
                sda_nxt = (nxt_q != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk50) begin
        if (!irst_n) begin
            state    <= ST_IDLE;
            q        <= '0;
            bit_idx  <= '0;
            byte_sel <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rw_r     <= RW_WRITE;
            dev_r    <= '0;
            reg_r    <= '0;
            wdata_r  <= '0;
            ack_bit  <= 1'b0;
            ordata   <= 8'h00;
            obusy    <= 1'b0;
            odone    <= 1'b0;
            oack_err <= 1'b0;
            oscl_oe  <= 1'b0;
            osda_oe  <= 1'b0;
        end else begin
            state    <= nxt_state;
            q        <= nxt_q;
            bit_idx  <= nxt_bit;
            byte_sel <= nxt_sel;
            tx_shift <= nxt_tx;
            oscl_oe  <= scl_nxt;
            osda_oe  <= sda_nxt;
            odone    <= 1'b0;
            if (accept) begin
                obusy    <= 1'b1;
                oack_err <= 1'b0;
                rw_r     <= irw;
                dev_r    <= idev_addr;
                reg_r    <= ireg_addr;
                wdata_r  <= iwdata;
            end
            if (nack_set) oack_err <= 1'b1;
            // SDA is sampled on entry to q3, mid-way through SCL high
            if (tick && q == 2'd2) begin
                if (state == ST_RX_ACK)  ack_bit  <= isda_in;
                if (state == ST_RX_BYTE) rx_shift <= {rx_shift[6:0], isda_in};
            end
            if (state == ST_DONE) begin
                odone <= 1'b1;
                obusy <= 1'b0;
                if (rw_r == RW_READ && !oack_err) ordata <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_master.sv
// tb/tb_i2c_reg_master.sv - directed table-driven bench with a behavioural I2C slave
module tb_i2c_reg_master;
    import i2c_pkg::*;

    localparam logic [6:0] SLV_ADDR = 7'h68;

    logic       iclk50 = 1'b0;
    logic       irst_n;
    logic       istart;
    logic       irw;
    logic [6:0] idev_addr;
    logic [7:0] ireg_addr;
    logic [7:0] iwdata;
    logic       isda_in;
    logic [7:0] ordata;
    logic       obusy, odone, oack_err, oscl_oe, osda_oe;

    i2c_reg_master dut (
        .iclk50    (iclk50),
        .irst_n    (irst_n),
        .istart    (istart),
        .irw       (irw),
        .idev_addr (idev_addr),
        .ireg_addr (ireg_addr),
        .iwdata    (iwdata),
        .isda_in   (isda_in),
        .ordata    (ordata),
        .obusy     (obusy),
        .odone     (odone),
        .oack_err  (oack_err),
        .oscl_oe   (oscl_oe),
        .osda_oe   (osda_oe)
    );

    always #10 iclk50 = ~iclk50;

    // Open-drain bus and slave model
    logic       slave_pull = 1'b0;
    logic       scl_line, sda_line;
    assign scl_line = ~oscl_oe;
    assign sda_line = ~osda_oe & ~slave_pull;
    assign isda_in  = sda_line;

    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       in_frame = 1'b0, in_ack = 1'b0, first = 1'b0;
    logic       addressed = 1'b0, next_tx = 1'b0, tx_mode = 1'b0, mack = 1'b0;
    logic [7:0] sh = 8'h00, tx_sh = 8'h00, srd = 8'h00;
    int         bitcnt = 0;
    logic [7:0] log_bytes [0:255];
    int         log_n = 0, starts_n = 0, stops_n = 0;

    always @(posedge iclk50) begin
        scl_p <= scl_line;
        sda_p <= sda_line;
        if (scl_p && scl_line && sda_p && !sda_line) begin
            in_frame <= 1'b1; in_ack <= 1'b0; first <= 1'b1; bitcnt <= 0;
            tx_mode <= 1'b0; mack <= 1'b0; slave_pull <= 1'b0;
            starts_n <= starts_n + 1;
        end else if (scl_p && scl_line && !sda_p && sda_line) begin
            in_frame <= 1'b0; slave_pull <= 1'b0;
            stops_n <= stops_n + 1;
        end else if (in_frame && !scl_p && scl_line) begin
            if (!in_ack && bitcnt < 8) begin
                sh <= {sh[6:0], sda_line};
                bitcnt <= bitcnt + 1;
            end else if (in_ack && tx_mode) begin
                mack <= sda_line;
            end
        end else if (in_frame && scl_p && !scl_line) begin
            if (bitcnt == 8 && !in_ack) begin
                in_ack <= 1'b1;
                if (tx_mode) begin
                    slave_pull <= 1'b0;
                end else begin
                    log_bytes[log_n] <= sh;
                    log_n <= log_n + 1;
                    if (first) begin
                        addressed  <= (sh[7:1] == SLV_ADDR);
                        next_tx    <= (sh[7:1] == SLV_ADDR) && sh[0];
                        slave_pull <= (sh[7:1] == SLV_ADDR);
                    end else begin
                        slave_pull <= addressed;
                    end
                end
            end else if (in_ack) begin
                in_ack <= 1'b0; bitcnt <= 0; first <= 1'b0;
                if ((first && next_tx) || (!first && tx_mode && !mack)) begin
                    tx_mode    <= 1'b1;
                    slave_pull <= ~srd[7];
                    tx_sh      <= {srd[6:0], 1'b0};
                end else begin
                    tx_mode    <= 1'b0;
                    slave_pull <= 1'b0;
                end
            end else if (tx_mode && bitcnt < 8) begin
                slave_pull <= ~tx_sh[7];
                tx_sh      <= {tx_sh[6:0], 1'b0};
            end
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic start_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        @(negedge iclk50);
        irw = rw; idev_addr = dev; ireg_addr = rg; iwdata = wd; istart = 1'b1;
        @(posedge iclk50);
        #1 istart = 1'b0;
    endtask

    // Counts edges after the accept edge until odone; optionally pulses istart at one point.
    task automatic wait_done(input int pulse_at, output int cycles);
        cycles = 0;
        while (!odone && cycles < 6000) begin
            if (pulse_at != 0 && cycles == pulse_at) begin
                irw = RW_READ; idev_addr = SLV_ADDR; ireg_addr = 8'h75; istart = 1'b1;
            end else begin
                istart = 1'b0;
            end
            @(posedge iclk50);
            #1 cycles++;
        end
        istart = 1'b0;
    endtask

    typedef struct {
        logic            rw;
        logic [6:0]      dev;
        logic [7:0]      rg;
        logic [7:0]      wd;
        logic [7:0]      srd;
        int              exp_cyc;
        logic            exp_err;
        logic [7:0]      exp_rdata;
        int              exp_nbytes;
        logic [2:0][7:0] exp_b;
        int              exp_starts;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc, base_log, base_st, base_sp, extra_done, busy_seen;

        vecs[0] = '{RW_WRITE, 7'h68, 8'h6B, 8'h00, 8'h00, 3597, 1'b0, 8'h00, 3, {8'h00, 8'h6B, 8'hD0}, 1};
        vecs[1] = '{RW_READ,  7'h68, 8'h75, 8'h00, 8'h71, 4837, 1'b0, 8'h71, 3, {8'hD1, 8'h75, 8'hD0}, 2};
        vecs[2] = '{RW_WRITE, 7'h50, 8'h6B, 8'h12, 8'h00, 1365, 1'b1, 8'h71, 1, {8'h00, 8'h00, 8'hA0}, 1};
        vecs[3] = '{RW_READ,  7'h50, 8'h75, 8'h00, 8'h55, 1365, 1'b1, 8'h71, 1, {8'h00, 8'h00, 8'hA0}, 1};
        vecs[4] = '{RW_READ,  7'h68, 8'h3B, 8'h00, 8'hC3, 4837, 1'b0, 8'hC3, 3, {8'hD1, 8'h3B, 8'hD0}, 2};
        vecs[5] = '{RW_WRITE, 7'h68, 8'h1A, 8'hA5, 8'h00, 3597, 1'b0, 8'hC3, 3, {8'hA5, 8'h1A, 8'hD0}, 1};

        irst_n = 1'b0; istart = 1'b1; irw = RW_WRITE;
        idev_addr = SLV_ADDR; ireg_addr = 8'h6B; iwdata = 8'h00;
        repeat (5) @(posedge iclk50);
        #1;
        chk("rst_scl_oe", oscl_oe, 0);
        chk("rst_sda_oe", osda_oe, 0);
        chk("rst_busy", obusy, 0);
        chk("rst_done", odone, 0);
        chk("rst_ack_err", oack_err, 0);
        chk("rst_rdata", ordata, 8'h00);
        @(negedge iclk50);
        istart = 1'b0; irst_n = 1'b1;
        repeat (3) @(posedge iclk50);

        for (int i = 0; i < 6; i++) begin
            base_log = log_n; base_st = starts_n; base_sp = stops_n;
            srd = vecs[i].srd;
            start_txn(vecs[i].rw, vecs[i].dev, vecs[i].rg, vecs[i].wd);
            wait_done(0, cyc);
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d_busy_at_done", i), obusy, 0);
            chk($sformatf("v%0d_ack_err", i), oack_err, vecs[i].exp_err);
            chk($sformatf("v%0d_rdata", i), ordata, vecs[i].exp_rdata);
            @(posedge iclk50);
            #1 chk($sformatf("v%0d_done_width", i), odone, 0);
            chk($sformatf("v%0d_nbytes", i), log_n - base_log, vecs[i].exp_nbytes);
            for (int k = 0; k < vecs[i].exp_nbytes; k++)
                chk($sformatf("v%0d_byte%0d", i, k), log_bytes[base_log + k], vecs[i].exp_b[k]);
            chk($sformatf("v%0d_starts", i), starts_n - base_st, vecs[i].exp_starts);
            chk($sformatf("v%0d_stops", i), stops_n - base_sp, 1);
            if (vecs[i].rw == RW_READ && !vecs[i].exp_err)
                chk($sformatf("v%0d_master_nack", i), mack, 1);
            repeat (5) @(posedge iclk50);
        end

        // istart while busy must be dropped, not queued
        base_log = log_n;
        start_txn(RW_WRITE, 7'h68, 8'h6B, 8'h00);
        wait_done(500, cyc);
        chk("pulse_cycles", cyc, 3597);
        chk("pulse_ack_err", oack_err, 0);
        chk("pulse_byte1", log_bytes[base_log + 1], 8'h6B);
        extra_done = 0; busy_seen = 0;
        repeat (200) begin
            @(posedge iclk50);
            #1;
            if (odone) extra_done++;
            if (obusy) busy_seen++;
        end
        chk("pulse_extra_done", extra_done, 0);
        chk("pulse_no_requeue", busy_seen, 0);

        // reset during byte 2, then a fresh read must complete normally
        start_txn(RW_WRITE, 7'h68, 8'h6B, 8'h00);
        chk("after_done_accept", obusy, 1);
        repeat (1549) @(posedge iclk50);
        @(negedge iclk50);
        irst_n = 1'b0;
        @(posedge iclk50);
        #1;
        chk("midrst_scl_oe", oscl_oe, 0);
        chk("midrst_sda_oe", osda_oe, 0);
        chk("midrst_busy", obusy, 0);
        chk("midrst_rdata", ordata, 8'h00);
        @(negedge iclk50);
        irst_n = 1'b1;
        repeat (40) @(posedge iclk50);
        base_log = log_n;
        srd = 8'h71;
        start_txn(RW_READ, 7'h68, 8'h75, 8'h00);
        wait_done(0, cyc);
        chk("postrst_cycles", cyc, 4837);
        chk("postrst_ack_err", oack_err, 0);
        chk("postrst_rdata", ordata, 8'h71);
        chk("postrst_byte2", log_bytes[base_log + 2], 8'hD1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_reg_master.md
Name: i2c_reg_master

Overview:
- Byte-level I2C master transaction engine for the MPU9250 link; the stage directly downstream of the 400 kHz I2C clock generator.
- Consumes the same quarter-bit timing (50 MHz / (400 kHz × 4)) and turns it into complete register transactions: single-byte write, or single-byte read with a repeated start.
- Drives open-drain SCL/SDA enables toward the pad; hands read data and status to the sensor-polling logic above it.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- I2C_HZ, 400000, target SCL frequency.
- QTR, CLK_HZ/(I2C_HZ*4) = 31, clock cycles per quarter-bit; must be ≥ 2.

Ports:
- iclk50  in  1  system clock, 50 MHz.
- irst_n  in  1  synchronous, active-low reset.
- istart  in  1  request; sampled only when obusy=0.
- irw  in  1  0 = register write, 1 = register read.
- idev_addr  in  7  slave address (MPU9250 = 7'h68).
- ireg_addr  in  8  register index.
- iwdata  in  8  write data (ignored for reads).
- isda_in  in  1  synchronised SDA pad level.
- ordata  out  8  read byte; valid when odone=1 and irw was 1.
- obusy  out  1  transaction in progress.
- odone  out  1  one-cycle completion pulse.
- oack_err  out  1  NACK seen; valid with odone, held until next accept.
- oscl_oe  out  1  1 = pull SCL low, 0 = release.
- osda_oe  out  1  1 = pull SDA low, 0 = release.

Behaviour:
- Clock and reset: one clock (iclk50). Reset is synchronous, active-low (irst_n).
- Reset values: oscl_oe=0, osda_oe=0 (bus released), obusy=0, odone=0, oack_err=0, ordata=8'h00, state IDLE, quarter counter 0.
- Accept: istart=1 && obusy=0 at a rising edge.
  - Latch irw, addresses and data.
  - obusy=1 from the next cycle.
  - Clear oack_err; clear the quarter counter so the first quarter is a full QTR cycles.
  - istart while busy is ignored, not queued.
- Quarter tick: asserted when the counter equals QTR-1; counter wraps to 0. Counts only while busy.
- Bit timing, 4 quarters per bit:
  - q0, q1: SCL low. SDA updates at q0 entry.
  - q2, q3: SCL released.
  - SDA sampled at q3 entry.
- Framing conditions:
  - START: SDA/SCL released q0–q1, SDA low at q2, SCL low at q3.
  - RESTART: SDA released q0, SCL released q1, SDA low q2, SCL low q3.
  - STOP: SDA low q0–q1, SCL released q2, SDA released q3.
  - Bytes are sent MSB first.
  - ACK bit: SDA released; ACK = sampled 0.
- FSM: IDLE → START → TX_BYTE → RX_ACK, then by sequence:
  - Write: addr+W, reg, data, then STOP → DONE.
  - Read: addr+W, reg, RESTART, addr+R, RX_BYTE, TX_NACK (SDA released), STOP → DONE.
  - DONE: odone=1 for one cycle, obusy=0 in that same cycle, return to IDLE.
- NACK on any RX_ACK: set oack_err=1, skip the remaining bytes, go to STOP → DONE. ordata is unchanged on error.
- Exact duration from accept edge to odone high (tests check these):
  - Write: 116 quarters (START 4 + 3×36 + STOP 4), so odone at cycle 116*QTR+1.
  - Read: 156 quarters, so odone at cycle 156*QTR+1.
- ordata updates only on successful completion of a read, in the DONE cycle.
- Reset mid-transaction: all outputs return to reset values on the next edge. The bus is released with no STOP generated.
- No clock stretching and no arbitration; single master assumed on the bus.

Decomposition:
- Package i2c_pkg:
  - FSM state enum.
  - RW_WRITE=0 / RW_READ=1.
  - MPU9250_ADDR=7'h68.
  - QTR derivation function.
  - Quarter/byte counter widths: byte bit index 4 bits (0..8); quarter index 2 bits.
- Sub-module i2c_qtr_tick: parameterised divider with clear and enable, one-cycle tick output.

Test Plan:
- Reset: hold irst_n=0 for 5 cycles with istart=1 → all outputs at reset values, no bus activity.
- Write 0x6B←0x00 to 0x68, slave model ACKs all → SDA bytes D0, 6B, 00; odone at cycle 3597 (QTR=31); oack_err=0.
- Read 0x75 (WHO_AM_I), slave ACKs and returns 0x71 → bytes D0, 75, RESTART, D1; NACK after data; ordata=0x71; odone at cycle 4837.
- Address NACK (write to 0x50, no slave) → STOP right after first ACK slot; odone with oack_err=1; ordata unchanged; total 44 quarters.
- istart pulsed mid-transaction → ignored; only one odone; a subsequent istart after odone is accepted.
- Reset asserted during byte 2 → next cycle oscl_oe=osda_oe=0, obusy=0; new transaction afterwards completes normally.
